// File: rtl/sig_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : sig_frame_rx
// Brief    : Serial frame receiver (start/data/parity/stop) with a
//            valid/ready output, error pulses and a good-frame counter.
// Revision : 1.0
// ============================================================================
module sig_frame_rx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sig,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overflow,
    output logic [CNT_W-1:0]  frame_count
);

    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BCW-1:0] C_LAST_BIT = BCW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4
    } state_t;

    state_t            r_state;
    logic [BCW-1:0]    r_bit_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic              r_par_bad;

    logic              w_par_req;
    logic [DATA_W-1:0] w_shift_next;
    logic              w_out_free;

    // Concatenate-then-drop keeps the LSB-first shift legal when DATA_W is 1.
    logic [DATA_W:0]   w_shift_wide;
    assign w_shift_wide = {sig, r_shreg};
    assign w_shift_next = w_shift_wide[DATA_W:1];

    assign w_out_free   = ~data_valid | data_ready;

    generate
        if (PARITY_EN != 0) begin : g_parity
            assign w_par_req = (^r_shreg) ^ (PARITY_ODD != 0);
        end else begin : g_no_parity
            assign w_par_req = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_par_bad   <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;

            // A load in the STOP branch below overrides this drop.
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!sig) begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= '0;
                        r_par_bad <= 1'b0;
                    end
                end

                S_DATA: begin
                    r_shreg   <= w_shift_next;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == C_LAST_BIT) begin
                        r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end

                S_PARITY: begin
                    r_par_bad <= (sig != w_par_req);
                    r_state   <= S_STOP;
                end

                S_STOP: begin
                    if (sig) begin
                        r_state <= S_IDLE;
                        if (r_par_bad) begin
                            parity_err <= 1'b1;
                        end else begin
                            frame_count <= frame_count + 1'b1;
                            if (w_out_free) begin
                                data_out   <= r_shreg;
                                data_valid <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end else begin
                        // Framing error wins over any pending parity mismatch.
                        frame_err <= 1'b1;
                        r_state   <= S_BREAK;
                    end
                end

                S_BREAK: begin
                    if (sig) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sig_frame_rx.sv
`default_nettype none
// Testbench for sig_frame_rx: scenario tasks with inline checks plus a
// scoreboard queue that is popped on every valid/ready transfer.
module tb_sig_frame_rx;

    logic        clk;
    logic        reset;
    logic        sig;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_ready;
    logic        frame_err;
    logic        parity_err;
    logic        overflow;
    logic [15:0] frame_count;

    int          checks   = 0;
    int          failures = 0;
    int          n_ferr   = 0;
    int          n_perr   = 0;
    int          n_ovf    = 0;
    logic [15:0] exp_count = '0;
    logic [7:0]  exp_q[$];
    logic        prev_ferr = 1'b0;
    logic        prev_perr = 1'b0;
    logic        prev_ovf  = 1'b0;

    sig_frame_rx #(
        .DATA_W     (8),
        .PARITY_EN  (1),
        .PARITY_ODD (0),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sig         (sig),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: sampled after the testbench has driven inputs for the next edge.
    always @(negedge clk) begin
        #2;
        if (data_valid === 1'b1 && data_ready === 1'b1 && reset === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got word %h, required none", data_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    failures++;
                    $display("FAIL sb_word: got %h, required %h", data_out, e);
                end
            end
        end
        if (frame_err === 1'b1) n_ferr++;
        if (parity_err === 1'b1) n_perr++;
        if (overflow === 1'b1) n_ovf++;
        if ((frame_err === 1'b1 && prev_ferr) || (parity_err === 1'b1 && prev_perr) ||
            (overflow === 1'b1 && prev_ovf)) begin
            checks++;
            failures++;
            $display("FAIL pulse_width: flag high 2 cycles (ferr=%b perr=%b ovf=%b), required 1",
                     frame_err, parity_err, overflow);
        end
        prev_ferr = (frame_err === 1'b1);
        prev_perr = (parity_err === 1'b1);
        prev_ovf  = (overflow === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic b);
        @(negedge clk);
        #1;
        sig = b;
    endtask

    task automatic send_body(input logic [7:0] d, input logic flip_par, input logic stop);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit((^d) ^ flip_par);
        drive_bit(stop);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop);
        drive_bit(1'b0);
        send_body(d, flip_par, stop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; sig = 1'b0; data_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({data_out, data_valid, frame_err, parity_err, overflow, frame_count} !== '0) begin
            failures++;
            $display("FAIL reset_hold: out=%h v=%b fe=%b pe=%b ov=%b cnt=%0d, required all 0",
                     data_out, data_valid, frame_err, parity_err, overflow, frame_count);
        end
        #1; reset = 1'b0; sig = 1'b1;
        idle(4);
        @(negedge clk);
        checks++;
        if ({data_out, data_valid, frame_err, parity_err, overflow, frame_count} !== '0) begin
            failures++;
            $display("FAIL reset_release: out=%h v=%b fe=%b pe=%b ov=%b cnt=%0d, required all 0",
                     data_out, data_valid, frame_err, parity_err, overflow, frame_count);
        end
    endtask

    task automatic test_good_frame();
        exp_q.push_back(8'hA5);
        exp_count++;
        send_frame(8'hA5, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'hA5 || frame_count !== exp_count) begin
            failures++;
            $display("FAIL good_a5: v=%b out=%h cnt=%0d, required v=1 out=a5 cnt=%0d",
                     data_valid, data_out, frame_count, exp_count);
        end
        #1; sig = 1'b1;
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b0) begin
            failures++;
            $display("FAIL good_a5_drop: v=%b, required 0", data_valid);
        end
        idle(2);
    endtask

    task automatic test_bad_stop();
        int f0;
        int p0;
        f0 = n_ferr; p0 = n_perr;
        send_frame(8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b1 || parity_err !== 1'b0 || data_valid !== 1'b0) begin
            failures++;
            $display("FAIL bad_stop_pulse: fe=%b pe=%b v=%b, required fe=1 pe=0 v=0",
                     frame_err, parity_err, data_valid);
        end
        #1; sig = 1'b0;
        repeat (3) drive_bit(1'b0);
        idle(3);
        @(negedge clk);
        checks++;
        if (n_ferr - f0 != 1 || n_perr != p0 || frame_count !== exp_count || data_valid !== 1'b0) begin
            failures++;
            $display("FAIL bad_stop_after: ferr=%0d perr=%0d cnt=%0d v=%b, required ferr=1 perr=0 cnt=%0d v=0",
                     n_ferr - f0, n_perr - p0, frame_count, data_valid, exp_count);
        end
        exp_q.push_back(8'h0F);
        exp_count++;
        send_frame(8'h0F, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h0F || frame_count !== exp_count) begin
            failures++;
            $display("FAIL good_0f: v=%b out=%h cnt=%0d, required v=1 out=0f cnt=%0d",
                     data_valid, data_out, frame_count, exp_count);
        end
        idle(2);
    endtask

    task automatic test_parity_err();
        int f0;
        int p0;
        f0 = n_ferr; p0 = n_perr;
        send_frame(8'h01, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (parity_err !== 1'b1 || frame_err !== 1'b0 || data_valid !== 1'b0) begin
            failures++;
            $display("FAIL parity_pulse: pe=%b fe=%b v=%b, required pe=1 fe=0 v=0",
                     parity_err, frame_err, data_valid);
        end
        idle(3);
        checks++;
        if (n_perr - p0 != 1 || n_ferr != f0 || frame_count !== exp_count) begin
            failures++;
            $display("FAIL parity_after: perr=%0d ferr=%0d cnt=%0d, required perr=1 ferr=0 cnt=%0d",
                     n_perr - p0, n_ferr - f0, frame_count, exp_count);
        end
    endtask

    task automatic test_backpressure();
        int o0;
        o0 = n_ovf;
        #1; data_ready = 1'b0;
        exp_q.push_back(8'h11);
        exp_count++;
        send_frame(8'h11, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h11 || frame_count !== exp_count) begin
            failures++;
            $display("FAIL bp_first: v=%b out=%h cnt=%0d, required v=1 out=11 cnt=%0d",
                     data_valid, data_out, frame_count, exp_count);
        end
        #1; sig = 1'b0;
        exp_count++;
        send_body(8'h22, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || data_valid !== 1'b1 || data_out !== 8'h11 || frame_count !== exp_count) begin
            failures++;
            $display("FAIL bp_overflow: ov=%b v=%b out=%h cnt=%0d, required ov=1 v=1 out=11 cnt=%0d",
                     overflow, data_valid, data_out, frame_count, exp_count);
        end
        #1; sig = 1'b1;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0 || data_out !== 8'h11) begin
            failures++;
            $display("FAIL bp_hold: ov=%b out=%h, required ov=0 out=11", overflow, data_out);
        end
        #1; data_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b0 || n_ovf - o0 != 1) begin
            failures++;
            $display("FAIL bp_release: v=%b ovf_pulses=%0d, required v=0 ovf_pulses=1",
                     data_valid, n_ovf - o0);
        end
        idle(2);
    endtask

    task automatic test_accept_load();
        int o0;
        o0 = n_ovf;
        #1; data_ready = 1'b0;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3);
        exp_count += 2;
        send_frame(8'h5A, 1'b0, 1'b1);
        idle(2);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(8'hC3 >> i);
        drive_bit(1'b0);
        @(negedge clk);
        #1; sig = 1'b1; data_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'hC3 || overflow !== 1'b0 || frame_count !== exp_count) begin
            failures++;
            $display("FAIL accept_load: v=%b out=%h ov=%b cnt=%0d, required v=1 out=c3 ov=0 cnt=%0d",
                     data_valid, data_out, overflow, frame_count, exp_count);
        end
        idle(1);
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b0 || n_ovf != o0) begin
            failures++;
            $display("FAIL accept_load_drop: v=%b ovf_pulses=%0d, required v=0 ovf_pulses=0",
                     data_valid, n_ovf - o0);
        end
        idle(1);
    endtask

    task automatic test_reset_midframe();
        int f0;
        int p0;
        int o0;
        f0 = n_ferr; p0 = n_perr; o0 = n_ovf;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(8'h77 >> i);
        @(negedge clk);
        #1; reset = 1'b1; sig = 1'b1;
        repeat (2) @(negedge clk);
        #1; reset = 1'b0;
        exp_count = '0;
        idle(2);
        checks++;
        if (frame_count !== 16'd0 || data_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_clear: cnt=%0d v=%b, required cnt=0 v=0", frame_count, data_valid);
        end
        exp_q.push_back(8'h99);
        exp_count++;
        send_frame(8'h99, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h99 || frame_count !== exp_count) begin
            failures++;
            $display("FAIL midreset_99: v=%b out=%h cnt=%0d, required v=1 out=99 cnt=%0d",
                     data_valid, data_out, frame_count, exp_count);
        end
        idle(4);
        checks++;
        if (n_ferr != f0 || n_perr != p0 || n_ovf != o0) begin
            failures++;
            $display("FAIL midreset_flags: ferr=%0d perr=%0d ovf=%0d, required all 0",
                     n_ferr - f0, n_perr - p0, n_ovf - o0);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_stop();
        test_parity_err();
        test_backpressure();
        test_accept_load();
        test_reset_midframe();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d words undelivered, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sig_frame_rx.md
Name: sig_frame_rx

Overview:
- Serial frame receiver: the DUT stage directly downstream of the single-bit `sig` interface.
- Consumes one `sig` bit per `clk` edge and recovers framed words: idle-high line, start bit 0, DATA_W data bits LSB first, optional parity bit, stop bit 1.
- Delivers each good word on a valid/ready output port, with error and overflow status pulses and a good-frame counter for the monitor/scoreboard.

Parameters:
- DATA_W, 8: data bits per frame (1..32).
- PARITY_EN, 1: 1 = a parity bit follows the data bits; 0 = no parity bit.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN=0.
- CNT_W, 16: width of frame_count.

Ports:
- clk, in, 1: single clock; all logic on posedge.
- reset, in, 1: synchronous, active-high reset.
- sig, in, 1: serial line, sampled on every posedge clk.
- data_out, out, DATA_W: received word; held stable while data_valid=1.
- data_valid, out, 1: output word available.
- data_ready, in, 1: consumer accepts; transfer occurs when data_valid & data_ready.
- frame_err, out, 1: 1-cycle pulse when the stop bit is sampled as 0.
- parity_err, out, 1: 1-cycle pulse when the parity check fails.
- overflow, out, 1: 1-cycle pulse when a good frame is dropped because the output is occupied.
- frame_count, out, CNT_W: count of good frames received; wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, active-high):
  - Clears the FSM to IDLE, the bit counter and the shift register.
  - data_out=0, data_valid=0, frame_err=0, parity_err=0, overflow=0, frame_count=0.
  - A reset asserted mid-frame abandons the frame; nothing is delivered and no flags pulse.
- FSM states: IDLE, DATA, PARITY, STOP, BREAK.
- IDLE: sig=0 -> DATA with bit_cnt=0. sig=1 -> stay in IDLE.
- DATA:
  - Each cycle: shreg <= {sig, shreg[DATA_W-1:1]} (LSB first); bit_cnt++.
  - After the DATA_W-th bit: -> PARITY if PARITY_EN=1, else -> STOP.
- PARITY:
  - Sample sig as p_rx. Required parity: XOR(shreg) ^ PARITY_ODD.
  - Latch mismatch = p_rx != required parity. -> STOP.
- STOP:
  - sig=1 and no parity mismatch: good frame; -> IDLE.
  - sig=1 and parity mismatch: parity_err pulses the next cycle; frame discarded; -> IDLE.
  - sig=0: frame_err pulses the next cycle (parity_err is suppressed); frame discarded; -> BREAK.
- BREAK: stay until sig=1, then -> IDLE. This prevents a stuck-low line from being decoded as repeated start bits.
- Good-frame delivery:
  - The cycle after the stop-bit sample: data_out=shreg, data_valid=1, frame_count+1.
  - Latency from stop-bit edge to data_valid = 1 cycle.
  - Back-to-back frames need no idle bit: a start bit may be sampled on the first cycle back in IDLE.
- Output hold: data_valid stays 1 and data_out stays stable until a cycle with data_ready=1. data_valid then drops the next cycle unless a new good frame loads in the same cycle.
- Overflow:
  - Good frame completes while data_valid=1 and data_ready=0: new frame dropped, old word kept, overflow pulses 1 cycle.
  - frame_count still increments, because the frame itself was good.
- Simultaneous accept and load: data_valid & data_ready in the same cycle a good frame completes -> new word loads, data_valid stays 1, no overflow.
- Status pulses are exactly 1 cycle wide. At most one of frame_err/parity_err pulses per frame.
- data_ready is ignored while data_valid=0.

Test Plan (DATA_W=8, PARITY_EN=1, PARITY_ODD=0, data_ready=1 unless stated):
1. Reset: hold reset for 3 cycles with sig=0 -> all outputs 0, no frame started. Release with sig=1 -> outputs remain 0.
2. Good frame 0xA5: sig = 0, 1,0,1,0,0,1,0,1, 0 (parity), 1 -> one cycle after the stop bit: data_out=0xA5, data_valid=1, frame_count=1. data_valid drops the next cycle.
3. Bad stop bit on 0x3C: stop bit sampled 0, line held low 4 cycles, then high -> frame_err single pulse, no data_valid, frame_count unchanged. A following good 0x0F frame is received correctly.
4. Parity error on 0x01: parity bit sent as 0 (required 1) -> parity_err single pulse, no data_valid, frame_count unchanged.
5. Backpressure: data_ready=0; send 0x11 then 0x22 back-to-back -> data_out stays 0x11, overflow pulses after the second stop bit, frame_count=2. data_ready=1 -> data_valid drops.
6. Reset mid-frame: assert reset after the 4th data bit of 0x77; after release send 0x99 -> only 0x99 is delivered, frame_count=1, no error flags.
